// File: rtl/juego_pkg.sv
// rtl/juego_pkg.sv - shared game constants and player life-state encoding
package juego_pkg;

    typedef enum logic [1:0] {
        JUEGO     = 2'd0,
        CHOQUE    = 2'd1,
        REAPARECE = 2'd2,
        FIN       = 2'd3
    } estado_t;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int VIDAS_INI = 3;
    localparam int V_TICK    = V_VISIBLE;

endpackage

// File: rtl/control_jugador_if.sv
// rtl/control_jugador_if.sv - player controller bus: raster position, buttons, collision and sprite outputs
interface control_jugador_if;

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       btn_izq;
    logic       btn_der;
    logic       choque;
    logic [9:0] posx;
    logic [9:0] posy;
    logic       visible;
    logic [1:0] vidas;
    logic [1:0] estado;
    logic       fin_juego;

    modport master (
        output hcount, vcount, btn_izq, btn_der, choque,
        input  posx, posy, visible, vidas, estado, fin_juego
    );

    modport slave (
        input  hcount, vcount, btn_izq, btn_der, choque,
        output posx, posy, visible, vidas, estado, fin_juego
    );

endinterface

// File: rtl/sincronizador_boton.sv
// rtl/sincronizador_boton.sv - two-flop synchronizer for an asynchronous button
module sincronizador_boton (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/control_jugador.sv
// rtl/control_jugador.sv - player car movement, collision latch and crash/respawn/game-over FSM
module control_jugador #(
    parameter int RESOLUCION_X  = 60,
    parameter int X_MIN         = 160,
    parameter int X_MAX         = 420,
    parameter int X_INICIO      = 260,
    parameter int Y_POS         = 400,
    parameter int PASO          = 4,
    parameter int V_TICK        = juego_pkg::V_TICK,
    parameter int CHOQUE_FRAMES = 96,
    parameter int INVUL_FRAMES  = 64,
    parameter int BLINK_FRAMES  = 8,
    parameter int VIDAS_INI     = juego_pkg::VIDAS_INI
) (
    input  logic               clock,
    input  logic               reset,
    control_jugador_if.slave   bus
);

    import juego_pkg::*;

    // Right limit is also clipped so the whole sprite stays on the visible line.
    localparam int X_LIM   = (X_MAX + RESOLUCION_X > H_VISIBLE) ? H_VISIBLE - RESOLUCION_X : X_MAX;
    localparam int CONT_MX = (CHOQUE_FRAMES > INVUL_FRAMES) ? CHOQUE_FRAMES : INVUL_FRAMES;
    localparam int CONT_W  = (CONT_MX > 1) ? $clog2(CONT_MX) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [10:0]        XMIN_C   = 11'(X_MIN);
    localparam logic [10:0]        XMAX_C   = 11'(X_LIM);
    localparam logic [10:0]        PASO_C   = 11'(PASO);
    localparam logic [9:0]         XINI_C   = 10'(X_INICIO);
    localparam logic [9:0]         VTICK_C  = 10'(V_TICK);
    localparam logic [CONT_W-1:0]  CHOQ_C   = CONT_W'(CHOQUE_FRAMES - 1);
    localparam logic [CONT_W-1:0]  INVUL_C  = CONT_W'(INVUL_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_C  = BLINK_W'(BLINK_FRAMES - 1);

    estado_t              estado_q, estado_d;
    logic [9:0]           posx_q, posx_d;
    logic [1:0]           vidas_q, vidas_d;
    logic [CONT_W-1:0]    cont_q, cont_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 visible_q, visible_d;
    logic                 pendiente_q, pendiente_d;
    logic                 fin_q, fin_d;

    logic        tick, izq_s, der_s, golpe, blink_fin;
    logic [10:0] pos_ext, pos_izq, pos_der;
    logic [9:0]  posx_mov;

    sincronizador_boton u_sync_izq (.clock(clock), .reset(reset), .d_i(bus.btn_izq), .q_o(izq_s));
    sincronizador_boton u_sync_der (.clock(clock), .reset(reset), .d_i(bus.btn_der), .q_o(der_s));

    assign tick      = (bus.hcount == 10'd0) && (bus.vcount == VTICK_C);
    assign golpe     = pendiente_q | bus.choque;
    assign blink_fin = (blink_q == BLINK_C);

    // Saturating move computed one bit wider so the edges never wrap.
    always_comb begin
        pos_ext  = {1'b0, posx_q};
        pos_izq  = (pos_ext < XMIN_C + PASO_C) ? XMIN_C : pos_ext - PASO_C;
        pos_der  = (pos_ext > XMAX_C - PASO_C) ? XMAX_C : pos_ext + PASO_C;
        posx_mov = posx_q;
        if (izq_s && !der_s) begin
            posx_mov = pos_izq[9:0];
        end else if (der_s && !izq_s) begin
            posx_mov = pos_der[9:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= JUEGO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (tick) begin
            case (estado_q)
                JUEGO:     if (golpe) estado_d = (vidas_q == 2'd1) ? FIN : CHOQUE;
                CHOQUE:    if (cont_q == '0) estado_d = REAPARECE;
                REAPARECE: if (cont_q == '0) estado_d = JUEGO;
                default:   estado_d = FIN;
            endcase
        end
    end

    always_comb begin
        posx_d      = posx_q;
        vidas_d     = vidas_q;
        cont_d      = cont_q;
        blink_d     = blink_q;
        visible_d   = visible_q;
        fin_d       = (estado_d == FIN);
        pendiente_d = tick ? 1'b0 : (pendiente_q | ((estado_q == JUEGO) && bus.choque));
        if (tick) begin
            case (estado_q)
                JUEGO: begin
                    if (golpe) begin
                        vidas_d = vidas_q - 2'd1;
                        if (estado_d == CHOQUE) begin
                            cont_d  = CHOQ_C;
                            blink_d = '0;
                        end else begin
                            visible_d = 1'b0;
                        end
                    end else begin
                        posx_d = posx_mov;
                    end
                end
                CHOQUE, REAPARECE: begin
                    if (estado_q == REAPARECE) posx_d = posx_mov;
                    if (cont_q == '0) begin
                        visible_d = 1'b1;
                        blink_d   = '0;
                        if (estado_q == CHOQUE) begin
                            posx_d = XINI_C;
                            cont_d = INVUL_C;
                        end
                    end else begin
                        cont_d  = cont_q - CONT_W'(1);
                        blink_d = blink_fin ? '0 : blink_q + BLINK_W'(1);
                        if (blink_fin) visible_d = ~visible_q;
                    end
                end
                default: visible_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            posx_q      <= XINI_C;
            vidas_q     <= 2'(VIDAS_INI);
            cont_q      <= '0;
            blink_q     <= '0;
            visible_q   <= 1'b1;
            pendiente_q <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            posx_q      <= posx_d;
            vidas_q     <= vidas_d;
            cont_q      <= cont_d;
            blink_q     <= blink_d;
            visible_q   <= visible_d;
            pendiente_q <= pendiente_d;
            fin_q       <= fin_d;
        end
    end

    assign bus.posx      = posx_q;
    assign bus.posy      = 10'(Y_POS);
    assign bus.visible   = visible_q;
    assign bus.vidas     = vidas_q;
    assign bus.estado    = estado_q;
    assign bus.fin_juego = fin_q;

endmodule

// File: tb/tb_control_jugador.sv
// tb/tb_control_jugador.sv - directed self-checking bench for control_jugador
module tb_control_jugador;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    control_jugador_if bus ();
    control_jugador_if bus_b ();

    control_jugador dut (.clock(clock), .reset(reset), .bus(bus.slave));
    // Second instance starts off the PASO grid so both saturation branches are reached.
    control_jugador #(.X_INICIO(262)) dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

    assign bus_b.hcount  = bus.hcount;
    assign bus_b.vcount  = bus.vcount;
    assign bus_b.btn_izq = bus.btn_izq;
    assign bus_b.btn_der = bus.btn_der;
    assign bus_b.choque  = 1'b0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic frame();
        bus.hcount = 10'd5;
        bus.vcount = 10'd100;
        repeat (3) step();
        bus.hcount = 10'd0;
        bus.vcount = 10'd480;
        step();
        bus.hcount = 10'd5;
        bus.vcount = 10'd100;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.btn_izq = 1'b0;
        bus.btn_der = 1'b0;
        bus.choque  = 1'b0;
        pulse_reset();
        checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL reset_posx: got %0d expected 260", bus.posx); end
        checks++; if (bus.posy !== 10'd400) begin errors++; $display("FAIL reset_posy: got %0d expected 400", bus.posy); end
        checks++; if (bus.visible !== 1'b1) begin errors++; $display("FAIL reset_visible: got %0b expected 1", bus.visible); end
        checks++; if (bus.vidas !== 2'd3) begin errors++; $display("FAIL reset_vidas: got %0d expected 3", bus.vidas); end
        checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", bus.estado); end
        checks++; if (bus.fin_juego !== 1'b0) begin errors++; $display("FAIL reset_fin: got %0b expected 0", bus.fin_juego); end
        bus.btn_der = 1'b1;
        repeat (4) step();
        checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL no_tick_hold: got %0d expected 260", bus.posx); end
        bus.btn_der = 1'b0;
    endtask

    task automatic test_left();
        int exp_a;
        int exp_b;
        pulse_reset();
        exp_a = 260;
        exp_b = 262;
        bus.btn_izq = 1'b1;
        for (int f = 0; f < 30; f++) begin
            frame();
            exp_a = (exp_a < 164) ? 160 : exp_a - 4;
            exp_b = (exp_b < 164) ? 160 : exp_b - 4;
            checks++; if (bus.posx !== 10'(exp_a)) begin errors++; $display("FAIL left_a f%0d: got %0d expected %0d", f, bus.posx, exp_a); end
            checks++; if (bus_b.posx !== 10'(exp_b)) begin errors++; $display("FAIL left_b f%0d: got %0d expected %0d", f, bus_b.posx, exp_b); end
        end
        bus.btn_izq = 1'b0;
    endtask

    task automatic test_right();
        int exp_a;
        int exp_b;
        pulse_reset();
        exp_a = 260;
        exp_b = 262;
        bus.btn_der = 1'b1;
        for (int f = 0; f < 100; f++) begin
            frame();
            exp_a = (exp_a > 416) ? 420 : exp_a + 4;
            exp_b = (exp_b > 416) ? 420 : exp_b + 4;
            checks++; if (bus.posx !== 10'(exp_a)) begin errors++; $display("FAIL right_a f%0d: got %0d expected %0d", f, bus.posx, exp_a); end
            checks++; if (bus_b.posx !== 10'(exp_b)) begin errors++; $display("FAIL right_b f%0d: got %0d expected %0d", f, bus_b.posx, exp_b); end
        end
    endtask

    task automatic test_both();
        bus.btn_izq = 1'b1;
        bus.btn_der = 1'b1;
        for (int f = 0; f < 5; f++) begin
            frame();
            checks++; if (bus.posx !== 10'd420) begin errors++; $display("FAIL both f%0d: got %0d expected 420", f, bus.posx); end
        end
        bus.btn_izq = 1'b0;
        bus.btn_der = 1'b0;
    endtask

    task automatic test_crash_cycle();
        logic ev;
        int   ep;
        pulse_reset();
        bus.choque = 1'b1;
        step();
        bus.choque = 1'b0;
        frame();
        checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL crash_vidas: got %0d expected 2", bus.vidas); end
        checks++; if (bus.estado !== 2'd1) begin errors++; $display("FAIL crash_estado: got %0d expected 1", bus.estado); end
        checks++; if (bus.visible !== 1'b1) begin errors++; $display("FAIL crash_visible: got %0b expected 1", bus.visible); end
        bus.choque  = 1'b1;
        bus.btn_der = 1'b1;
        for (int k = 1; k <= 96; k++) begin
            frame();
            if (k < 96) begin
                ev = ((k / 8) % 2) == 0;
                checks++; if (bus.estado !== 2'd1) begin errors++; $display("FAIL choque_estado k%0d: got %0d expected 1", k, bus.estado); end
                checks++; if (bus.visible !== ev) begin errors++; $display("FAIL blink k%0d: got %0b expected %0b", k, bus.visible, ev); end
                checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL choque_posx k%0d: got %0d expected 260", k, bus.posx); end
            end else begin
                checks++; if (bus.estado !== 2'd2) begin errors++; $display("FAIL reaparece_estado: got %0d expected 2", bus.estado); end
                checks++; if (bus.visible !== 1'b1) begin errors++; $display("FAIL reaparece_visible: got %0b expected 1", bus.visible); end
                checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL reaparece_posx: got %0d expected 260", bus.posx); end
            end
            checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL choque_vidas k%0d: got %0d expected 2", k, bus.vidas); end
        end
        for (int j = 1; j <= 64; j++) begin
            if (j == 64) bus.btn_der = 1'b0;
            frame();
            ep = (260 + 4 * j > 420) ? 420 : 260 + 4 * j;
            if (j < 64) begin
                checks++; if (bus.estado !== 2'd2) begin errors++; $display("FAIL invul_estado j%0d: got %0d expected 2", j, bus.estado); end
                checks++; if (bus.posx !== 10'(ep)) begin errors++; $display("FAIL invul_posx j%0d: got %0d expected %0d", j, bus.posx, ep); end
            end else begin
                checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL back_estado: got %0d expected 0", bus.estado); end
                checks++; if (bus.visible !== 1'b1) begin errors++; $display("FAIL back_visible: got %0b expected 1", bus.visible); end
                checks++; if (bus.posx !== 10'd420) begin errors++; $display("FAIL back_posx: got %0d expected 420", bus.posx); end
            end
            checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL invul_vidas j%0d: got %0d expected 2", j, bus.vidas); end
        end
        bus.choque = 1'b0;
        frame();
        checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL after_estado: got %0d expected 0", bus.estado); end
        checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL after_vidas: got %0d expected 2", bus.vidas); end
    endtask

    task automatic test_reset_mid_choque();
        pulse_reset();
        bus.choque = 1'b1;
        step();
        bus.choque = 1'b0;
        frames(41);
        checks++; if (bus.estado !== 2'd1) begin errors++; $display("FAIL mid_pre_estado: got %0d expected 1", bus.estado); end
        pulse_reset();
        checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL mid_estado: got %0d expected 0", bus.estado); end
        checks++; if (bus.vidas !== 2'd3) begin errors++; $display("FAIL mid_vidas: got %0d expected 3", bus.vidas); end
        checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL mid_posx: got %0d expected 260", bus.posx); end
        checks++; if (bus.visible !== 1'b1) begin errors++; $display("FAIL mid_visible: got %0b expected 1", bus.visible); end
    endtask

    task automatic test_choque_on_tick();
        pulse_reset();
        bus.btn_der = 1'b1;
        bus.hcount  = 10'd5;
        bus.vcount  = 10'd100;
        repeat (3) step();
        bus.hcount = 10'd0;
        bus.vcount = 10'd480;
        bus.choque = 1'b1;
        step();
        bus.choque = 1'b0;
        bus.hcount = 10'd5;
        bus.vcount = 10'd100;
        bus.btn_der = 1'b0;
        checks++; if (bus.vidas !== 2'd2) begin errors++; $display("FAIL tick_vidas: got %0d expected 2", bus.vidas); end
        checks++; if (bus.estado !== 2'd1) begin errors++; $display("FAIL tick_estado: got %0d expected 1", bus.estado); end
        checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL tick_posx: got %0d expected 260", bus.posx); end
    endtask

    task automatic test_fin();
        pulse_reset();
        for (int h = 1; h <= 3; h++) begin
            for (int p = 0; p < 3; p++) begin
                bus.choque = 1'b1;
                step();
                bus.choque = 1'b0;
                step();
            end
            frame();
            checks++; if (bus.vidas !== 2'(3 - h)) begin errors++; $display("FAIL fin_vidas h%0d: got %0d expected %0d", h, bus.vidas, 3 - h); end
            if (h < 3) begin
                checks++; if (bus.estado !== 2'd1) begin errors++; $display("FAIL fin_hit_estado h%0d: got %0d expected 1", h, bus.estado); end
                frames(160);
                checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL fin_back h%0d: got %0d expected 0", h, bus.estado); end
            end
        end
        checks++; if (bus.estado !== 2'd3) begin errors++; $display("FAIL fin_estado: got %0d expected 3", bus.estado); end
        checks++; if (bus.fin_juego !== 1'b1) begin errors++; $display("FAIL fin_flag: got %0b expected 1", bus.fin_juego); end
        checks++; if (bus.visible !== 1'b0) begin errors++; $display("FAIL fin_visible: got %0b expected 0", bus.visible); end
        bus.btn_der = 1'b1;
        bus.choque  = 1'b1;
        frames(3);
        bus.btn_der = 1'b0;
        bus.choque  = 1'b0;
        checks++; if (bus.estado !== 2'd3) begin errors++; $display("FAIL fin_stay: got %0d expected 3", bus.estado); end
        checks++; if (bus.posx !== 10'd260) begin errors++; $display("FAIL fin_posx: got %0d expected 260", bus.posx); end
        checks++; if (bus.vidas !== 2'd0) begin errors++; $display("FAIL fin_vidas_hold: got %0d expected 0", bus.vidas); end
        pulse_reset();
        checks++; if (bus.estado !== 2'd0) begin errors++; $display("FAIL fin_reset_estado: got %0d expected 0", bus.estado); end
        checks++; if (bus.fin_juego !== 1'b0) begin errors++; $display("FAIL fin_reset_flag: got %0b expected 0", bus.fin_juego); end
        checks++; if (bus.vidas !== 2'd3) begin errors++; $display("FAIL fin_reset_vidas: got %0d expected 3", bus.vidas); end
        checks++; if (bus.visible !== 1'b1) begin errors++; $display("FAIL fin_reset_visible: got %0b expected 1", bus.visible); end
    endtask

    initial begin
        reset       = 1'b1;
        bus.hcount  = 10'd5;
        bus.vcount  = 10'd100;
        bus.btn_izq = 1'b0;
        bus.btn_der = 1'b0;
        bus.choque  = 1'b0;
        repeat (2) step();
        test_reset();
        test_left();
        test_right();
        test_both();
        test_crash_cycle();
        test_reset_mid_choque();
        test_choque_on_tick();
        test_fin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_jugador.md
# control_jugador

Movement and life-state controller for the player car sprite. Samples the left/right buttons, updates `posx`/`posy` once per frame during vertical blanking, and latches collisions reported by the pixel compositor. Runs a crash/respawn/game-over state machine and drives the sprite unit's `enable` (visibility/blink), position inputs and the life counter. Sits between the board inputs and the player sprite renderer on the 640x480 VGA pipeline.

## Interface
Parameters:
- `RESOLUCION_X`, 60, sprite width in pixels
- `X_MIN`, 160, leftmost allowed `posx` (road edge)
- `X_MAX`, 420, rightmost allowed `posx`; the sprite spans `posx..posx+RESOLUCION_X-1`
- `X_INICIO`, 260, `posx` at reset and respawn
- `Y_POS`, 400, fixed `posy`
- `PASO`, 4, pixels moved per frame
- `V_TICK`, 480, `vcount` value that starts vertical blanking
- `CHOQUE_FRAMES`, 96, frames spent in CHOQUE
- `INVUL_FRAMES`, 64, frames spent in REAPARECE
- `BLINK_FRAMES`, 8, frames per visibility toggle while blinking
- `VIDAS_INI`, 3, lives at reset

Ports:
- `clock`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high
- `hcount`  in  10  current pixel column
- `vcount`  in  10  current pixel row
- `btn_izq`  in  1  left button, asynchronous, active-high
- `btn_der`  in  1  right button, asynchronous, active-high
- `choque`  in  1  collision; high for any overlapping player/obstacle pixel
- `posx`  out  10  sprite X origin
- `posy`  out  10  sprite Y origin, always `Y_POS`
- `visible`  out  1  drives the sprite unit `enable`
- `vidas`  out  2  remaining lives
- `estado`  out  2  JUEGO=0, CHOQUE=1, REAPARECE=2, FIN=3
- `fin_juego`  out  1  high while in FIN

## Operation
- `tick` is internal: one cycle, high when `hcount==0 && vcount==V_TICK`. All position, counter and state updates happen only on `tick`.
- Buttons pass through a 2-flop synchronizer and are evaluated at `tick`.
- Movement at `tick`, in JUEGO and REAPARECE only:
  - left only: `posx = (posx < X_MIN+PASO) ? X_MIN : posx-PASO`
  - right only: `posx = (posx > X_MAX-PASO) ? X_MAX : posx+PASO`
  - both or neither: hold
  - Compute in 11 bits; `posx` never leaves `[X_MIN, X_MAX]`.
- `pendiente` flag:
  - Set by `choque` in JUEGO.
  - Cleared at every `tick`.
  - `choque` is ignored in CHOQUE, REAPARECE and FIN.
- JUEGO, at `tick` with `pendiente|choque`:
  - Suppress movement for that tick and decrement `vidas`.
  - If old `vidas==1`: go to FIN.
  - Otherwise: go to CHOQUE with `cont=CHOQUE_FRAMES-1` and `blink=0`.
- CHOQUE:
  - No movement.
  - Each `tick`: `cont--` and `blink++`; `visible` toggles when `blink` wraps at `BLINK_FRAMES`.
  - At `tick` with `cont==0`: go to REAPARECE with `posx=X_INICIO`, `visible=1`, `cont=INVUL_FRAMES-1`.
- REAPARECE:
  - Movement allowed, same blink behaviour as CHOQUE.
  - At `tick` with `cont==0`: go to JUEGO with `visible=1`.
- FIN: `visible=0`, `posx` held, `fin_juego=1`. Only `reset` exits FIN.

## Timing
- Reset values (one cycle after `reset` is sampled high): `posx=X_INICIO`, `posy=Y_POS`, `visible=1`, `vidas=VIDAS_INI`, `estado=JUEGO`, `fin_juego=0`. `pendiente`, `cont`, `blink` and the synchronizers are cleared.
- `reset` asserted mid-CHOQUE or mid-FIN aborts immediately to the reset values.
- All outputs are registered. They change only in the cycle after `tick`, so they are stable during active video (no tearing).
- Button-to-sample latency is 2 cycles. A press must be stable by cycle `tick-2` to count for that frame.
- `choque` in the same cycle as `tick` counts for the current frame.
- At most one life is lost per frame, regardless of how many `choque` cycles occur.

## Structure
- Shared package `juego_pkg`:
  - state encoding `JUEGO/CHOQUE/REAPARECE/FIN`
  - `VIDAS_INI`, `V_TICK`, screen constants (640, 480)
- Sub-module `sincronizador_boton`: 2-flop synchronizer, instanced once per button.
- FSM, counters and position datapath stay in `control_jugador`.

## Test plan
- Reset, then hold `btn_der` for 100 frames -> `posx` goes 260, 264, … and saturates at 420; never 424.
- Hold both buttons for 5 frames -> `posx` unchanged. Hold `btn_izq` starting from `posx=162` -> `posx=160` after one tick, then holds.
- Pulse `choque` for 1 cycle mid-frame -> at the next tick `vidas` 3->2 and `estado=CHOQUE`. `visible` toggles every 8 ticks. After 96 ticks: `estado=REAPARECE`, `posx=260`. After 64 more ticks: `estado=JUEGO`.
- Hold `choque` during CHOQUE/REAPARECE -> `vidas` unchanged. Three hits in JUEGO -> `estado=FIN`, `fin_juego=1`, `visible=0`, `vidas=0`.
- Assert `reset` at tick 40 of CHOQUE -> next cycle `estado=JUEGO`, `vidas=3`, `posx=260`, `visible=1`.
- Assert `choque` exactly on the tick cycle -> a life is lost on that tick, with no movement applied.
